gemm_loop_controller: RTL

//  Sequences a 3-level loop nest (M outer, N middle, K inner) for the GEMM datapath.

---
 rtl/gemm_loop_controller.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/gemm_loop_controller.sv
`default_nettype none
// ============================================================================
// gemm_loop_controller : (m,n,k) index sequencer for the GEMM datapath with
//                        start/busy/done control and a valid/ready index stream
// Revision 1.0 - initial release
// ============================================================================
module gemm_loop_controller #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] bound_m_i,
  input  logic [WIDTH-1:0] bound_n_i,
  input  logic [WIDTH-1:0] bound_k_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             idx_valid_o,
  input  logic             idx_ready_i,
  output logic [WIDTH-1:0] idx_m_o,
  output logic [WIDTH-1:0] idx_n_o,
  output logic [WIDTH-1:0] idx_k_o,
  output logic             first_k_o,
  output logic             last_k_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] c_zero = '0;
  localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_bnd_m, r_bnd_n, r_bnd_k;
  logic [WIDTH-1:0] r_m, r_n, r_k;
  logic             r_busy, r_done, r_valid, r_first_k, r_last_k;

  logic             w_fire, w_k_last, w_n_last, w_m_last, w_any_zero;
  logic [WIDTH-1:0] w_k_nxt, w_n_nxt, w_m_nxt;

  // Wrap tests compare against bound-1 at full width, so bound=2^W-1 never overflows
  always_comb begin
    w_fire     = r_valid && idx_ready_i;
    w_k_last   = (r_k == r_bnd_k - c_one);
    w_n_last   = (r_n == r_bnd_n - c_one);
    w_m_last   = (r_m == r_bnd_m - c_one);
    w_any_zero = (bound_m_i == c_zero) || (bound_n_i == c_zero) || (bound_k_i == c_zero);
    w_k_nxt    = w_k_last ? c_zero : r_k + c_one;
    w_n_nxt    = w_k_last ? (w_n_last ? c_zero : r_n + c_one) : r_n;
    w_m_nxt    = (w_k_last && w_n_last) ? r_m + c_one : r_m;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_bnd_m   <= c_zero;
      r_bnd_n   <= c_zero;
      r_bnd_k   <= c_zero;
      r_m       <= c_zero;
      r_n       <= c_zero;
      r_k       <= c_zero;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_valid   <= 1'b0;
      r_first_k <= 1'b0;
      r_last_k  <= 1'b0;
    end else if (clear_i) begin
      r_state   <= S_IDLE;
      r_m       <= c_zero;
      r_n       <= c_zero;
      r_k       <= c_zero;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_valid   <= 1'b0;
      r_first_k <= 1'b0;
      r_last_k  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            if (w_any_zero) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state   <= S_RUN;
              r_bnd_m   <= bound_m_i;
              r_bnd_n   <= bound_n_i;
              r_bnd_k   <= bound_k_i;
              r_m       <= c_zero;
              r_n       <= c_zero;
              r_k       <= c_zero;
              r_busy    <= 1'b1;
              r_valid   <= 1'b1;
              r_first_k <= 1'b1;
              r_last_k  <= (bound_k_i == c_one);
            end
          end
        end
        S_RUN: begin
          if (w_fire) begin
            if (w_k_last && w_n_last && w_m_last) begin
              r_state   <= S_DONE;
              r_m       <= c_zero;
              r_n       <= c_zero;
              r_k       <= c_zero;
              r_busy    <= 1'b0;
              r_valid   <= 1'b0;
              r_done    <= 1'b1;
              r_first_k <= 1'b0;
              r_last_k  <= 1'b0;
            end else begin
              r_m       <= w_m_nxt;
              r_n       <= w_n_nxt;
              r_k       <= w_k_nxt;
              // Flags are precomputed for the tuple being loaded
              r_first_k <= w_k_last;
              r_last_k  <= (w_k_nxt == r_bnd_k - c_one);
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_valid <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign idx_valid_o = r_valid;
  assign idx_m_o     = r_m;
  assign idx_n_o     = r_n;
  assign idx_k_o     = r_k;
  assign first_k_o   = r_first_k;
  assign last_k_o    = r_last_k;

endmodule
`default_nettype wire
